hazard_ctrl: RTL
================

// Module: hazard_ctrl
// PURPOSE
//  Pipeline sequencer for the 5-stage core. Drives the IF/ID and ID/EX register enables and flushes, and the PC source.
//  Handles load-use stalls, taken-branch/JALR flushes, data-memory wait and trap drain/redirect.
//  Sits beside the ID/EX stage; ID/EX loads a bubble (all zeros) whenever IDEX_write=0.
// PARAMETERS
//  DRAIN_CYCLES  2   cycles spent in TRAP_DRAIN before redirecting to the trap vector (1..15)
//  CNT_W         32  width of the stall_cycles performance counter
// PORTS
//  clk            in   1      core clock, rising edge
//  reset          in   1      asynchronous, active-low reset
//  id_rs1,id_rs2  in   5      source register addresses of the instruction in ID
//  id_use_rs1/2   in   1      ID instruction actually reads rs1/rs2
//  ex_rd          in   5      destination register address in EX
//  ex_memRead     in   1      EX instruction is a load
//  ex_br_taken    in   1      EX branch taken or JALR (resolved this cycle)
//  ex_trapReq     in   1      EX instruction raises a trap
//  mem_busy       in   1      data memory not ready; MEM stage must hold
//  pc_write       out  1      PC register enable
//  IFID_write     out  1      IF/ID enable; 0 = hold
//  IFID_flush     out  1      IF/ID load NOP
//  IDEX_write     out  1      ID/EX enable; 0 = bubble into EX
//  flush_branch   out  1      ID/EX flush
//  mem_hold       out  1      EX/MEM and MEM/WB hold
//  pc_sel         out  2      00 pc+4, 01 branch target, 10 trap vector
//  stall_cycles   out  CNT_W  saturating count of cycles with pc_write=0
// BEHAVIOUR
//  Reset (reset=0, async):
//  - state=RUN, drain counter=0, stall_cycles=0.
//  - While reset is held, outputs are forced: pc_write=IFID_write=IDEX_write=0, flushes=0, mem_hold=0, pc_sel=00.
//  Output style: outputs are combinational from the registered state and the current inputs (same-cycle response).
//  Hazard definition: lu_hazard = ex_memRead & ex_rd!=0 & ((id_use_rs1 & ex_rd==id_rs1) | (id_use_rs2 & ex_rd==id_rs2)).
//  States:
//  - RUN, priority trap > mem_busy > branch > load-use:
//    . ex_trapReq: flush_branch=1, IFID_flush=1, pc_write=0; load count=DRAIN_CYCLES-1; ->TRAP_DRAIN.
//    . mem_busy: pc_write=IFID_write=0, IDEX_write=1 (EX re-latched, no bubble), mem_hold=1; ->MEM_WAIT.
//    . ex_br_taken: pc_sel=01, pc_write=1, IFID_flush=1, flush_branch=1; stay RUN.
//    . lu_hazard: pc_write=IFID_write=0, IDEX_write=0 (one bubble); ->RUN. The hazard clears next cycle because the load has left EX.
//    . else: all enables 1, pc_sel=00.
//  - MEM_WAIT: outputs as for mem_busy in RUN while mem_busy=1. On mem_busy=0: outputs normal, ->RUN.
//    . ex_trapReq / ex_br_taken are ignored until exit; EX is frozen, so they stay valid and are acted on in RUN.
//  - TRAP_DRAIN: pc_write=IFID_write=IDEX_write=0, mem_hold=mem_busy. Count decrements only when mem_busy=0.
//    . ->TRAP_REDIR when count==0 & mem_busy=0.
//  - TRAP_REDIR: pc_sel=10, pc_write=1, IFID_flush=1, flush_branch=1; ->RUN.
//  - A trap arriving in the same cycle as a branch takes trap priority; the branch is discarded.
//  - Illegal state encodings return to RUN with RUN outputs.
//  stall_cycles: +1 each cycle with pc_write=0 outside reset; saturates at all-ones, no wrap.
//  Reset mid-trap or mid-wait aborts immediately to RUN; no redirect is issued.
// STRUCTURE
//  Shared package (core_pkg): state encoding typedef (RUN, MEM_WAIT, TRAP_DRAIN, TRAP_REDIR) and PC_SEL_* constants.
//  The same PC_SEL_* constants are used by the PC mux.
//  Single module plus one sub-module: hazard_detect (combinational lu_hazard compare).
// TESTING
//  1. LW x5 in EX, ID reads x5 as rs1 -> one cycle pc_write=0, IDEX_write=0; next cycle all 1; stall_cycles=1.
//  2. LW x0 in EX, ID reads x0 -> no stall.
//     LW x5 in EX, ID with id_use_rs2=0 and rs2=5 -> no stall.
//  3. ex_br_taken=1 -> same cycle pc_sel=01, IFID_flush=1, flush_branch=1, pc_write=1.
//  4. mem_busy high 3 cycles -> mem_hold=1 and pc_write=0 for 3 cycles, IDEX_write=1; RUN on 4th; stall_cycles=3.
//  5. ex_trapReq & ex_br_taken together, DRAIN_CYCLES=2 -> flush, 2 drain cycles, then pc_sel=10 for 1 cycle; pc_sel=01 never seen.
//  6. reset=0 mid TRAP_DRAIN -> outputs at reset values immediately, no pc_sel=10 after release.
//     Counter forced to 0x...FFFE then 3 stalls -> saturates at all-ones.

Source files
------------

// File: rtl/core_pkg.sv
// Shared core definitions: hazard sequencer state encoding and PC source select codes.
package core_pkg;

    localparam int unsigned REG_ADDR_W  = 5;
    localparam int unsigned PC_SEL_W    = 2;
    localparam int unsigned DRAIN_CNT_W = 4;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        MEM_WAIT   = 2'd1,
        TRAP_DRAIN = 2'd2,
        TRAP_REDIR = 2'd3
    } hz_state_e;

    // PC mux select codes, shared with the PC mux
    localparam logic [PC_SEL_W-1:0] PC_SEL_PC4    = 2'b00;
    localparam logic [PC_SEL_W-1:0] PC_SEL_BRANCH = 2'b01;
    localparam logic [PC_SEL_W-1:0] PC_SEL_TRAP   = 2'b10;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard compare between the load in EX and the source operands of the instruction in ID.
module hazard_detect
    import core_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] id_rs1_i,
    input  logic [REG_ADDR_W-1:0] id_rs2_i,
    input  logic                  id_use_rs1_i,
    input  logic                  id_use_rs2_i,
    input  logic [REG_ADDR_W-1:0] ex_rd_i,
    input  logic                  ex_mem_read_i,
    output logic                  lu_hazard_o
);

    logic rs1_match;
    logic rs2_match;

    assign rs1_match   = id_use_rs1_i && (ex_rd_i == id_rs1_i);
    assign rs2_match   = id_use_rs2_i && (ex_rd_i == id_rs2_i);
    // x0 is never written, so a load targeting it cannot create a dependency
    assign lu_hazard_o = ex_mem_read_i && (ex_rd_i != '0) && (rs1_match || rs2_match);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencer: load-use stalls, branch/trap flushes, data-memory wait and trap drain/redirect.
module hazard_ctrl
    import core_pkg::*;
#(
    parameter int unsigned DRAIN_CYCLES = 2,
    parameter int unsigned CNT_W        = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_memRead,
    input  logic                  ex_br_taken,
    input  logic                  ex_trapReq,
    input  logic                  mem_busy,
    output logic                  pc_write,
    output logic                  IFID_write,
    output logic                  IFID_flush,
    output logic                  IDEX_write,
    output logic                  flush_branch,
    output logic                  mem_hold,
    output logic [PC_SEL_W-1:0]   pc_sel,
    output logic [CNT_W-1:0]      stall_cycles
);

    hz_state_e              state_q, state_d;
    logic [DRAIN_CNT_W-1:0] drain_q, drain_d;
    logic [CNT_W-1:0]       stall_q, stall_d;
    logic                   lu_hazard;
    logic                   run_eval;

    hazard_detect u_hazard_detect (
        .id_rs1_i      (id_rs1),
        .id_rs2_i      (id_rs2),
        .id_use_rs1_i  (id_use_rs1),
        .id_use_rs2_i  (id_use_rs2),
        .ex_rd_i       (ex_rd),
        .ex_mem_read_i (ex_memRead),
        .lu_hazard_o   (lu_hazard)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= RUN;
            drain_q <= '0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
            stall_q <= stall_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        drain_d      = drain_q;
        stall_d      = stall_q;
        run_eval     = 1'b0;
        pc_write     = 1'b1;
        IFID_write   = 1'b1;
        IFID_flush   = 1'b0;
        IDEX_write   = 1'b1;
        flush_branch = 1'b0;
        mem_hold     = 1'b0;
        pc_sel       = PC_SEL_PC4;

        case (state_q)
            // EX is frozen here, so pending trap/branch requests survive until exit
            MEM_WAIT: begin
                if (mem_busy) begin
                    pc_write   = 1'b0;
                    IFID_write = 1'b0;
                    mem_hold   = 1'b1;
                end else begin
                    run_eval = 1'b1;
                end
            end
            TRAP_DRAIN: begin
                pc_write   = 1'b0;
                IFID_write = 1'b0;
                IDEX_write = 1'b0;
                mem_hold   = mem_busy;
                if (!mem_busy) begin
                    if (drain_q == '0) begin
                        state_d = TRAP_REDIR;
                    end else begin
                        drain_d = drain_q - DRAIN_CNT_W'(1);
                    end
                end
            end
            TRAP_REDIR: begin
                pc_sel       = PC_SEL_TRAP;
                IFID_flush   = 1'b1;
                flush_branch = 1'b1;
                state_d      = RUN;
            end
            default: run_eval = 1'b1;
        endcase

        // RUN decision, priority trap > mem_busy > branch > load-use
        if (run_eval) begin
            state_d = RUN;
            if (ex_trapReq) begin
                pc_write     = 1'b0;
                IFID_flush   = 1'b1;
                flush_branch = 1'b1;
                drain_d      = DRAIN_CNT_W'(DRAIN_CYCLES - 1);
                state_d      = TRAP_DRAIN;
            end else if (mem_busy) begin
                pc_write   = 1'b0;
                IFID_write = 1'b0;
                mem_hold   = 1'b1;
                state_d    = MEM_WAIT;
            end else if (ex_br_taken) begin
                pc_sel       = PC_SEL_BRANCH;
                IFID_flush   = 1'b1;
                flush_branch = 1'b1;
            end else if (lu_hazard) begin
                pc_write   = 1'b0;
                IFID_write = 1'b0;
                IDEX_write = 1'b0;
            end
        end

        if (!reset) begin
            pc_write     = 1'b0;
            IFID_write   = 1'b0;
            IFID_flush   = 1'b0;
            IDEX_write   = 1'b0;
            flush_branch = 1'b0;
            mem_hold     = 1'b0;
            pc_sel       = PC_SEL_PC4;
        end

        if (!pc_write && (stall_q != {CNT_W{1'b1}})) begin
            stall_d = stall_q + CNT_W'(1);
        end
    end

    assign stall_cycles = stall_q;

endmodule
